// File: rtl/sha_req_queue.sv
// sha_req_queue: first-word-fall-through register FIFO holding SHA job descriptors for sha_fsm.
// Define REQQ_ERR_EN to add a sticky overflow flag (err_overflow) with its clear input (err_clr).
module sha_req_queue #(
    parameter int ADDRW = 24,
    parameter int DEPTH = 4,
    localparam int DW = 2*ADDRW + 2,
    localparam int PW = $clog2(DEPTH),
    localparam int LW = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          flush,
    output logic          req_valid,
    output logic [DW-1:0] req_data,
    input  logic          ready_req_out,
`ifdef REQQ_ERR_EN
    output logic          err_overflow,
    input  logic          err_clr,
`endif
    output logic [LW-1:0] level
);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          push;
    logic          pop;

    // Full/empty come only from count, so pointers can wrap freely.
    assign in_ready  = (count != LW'(DEPTH));
    assign req_valid = (count != '0);
    assign level     = count;
    assign req_data  = req_valid ? mem[rd_ptr] : '0;

    assign push = in_valid & in_ready;
    assign pop  = req_valid & ready_req_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Storage is not reset; a write is suppressed whenever reset or flush wins.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push)
            mem[wr_ptr] <= in_data;
    end

`ifdef REQQ_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            err_overflow <= 1'b0;
        else if (in_valid && !in_ready && !flush)
            err_overflow <= 1'b1;
        else if (err_clr)
            err_overflow <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_sha_req_queue.sv
// Scoreboard bench for sha_req_queue: stimulus updates a queue-based reference model,
// a negedge monitor compares every DUT output against it.
module tb_sha_req_queue;

    localparam int ADDRW = 24;
    localparam int DEPTH = 4;
    localparam int DW    = 2*ADDRW + 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          flush;
    logic          req_valid;
    logic [DW-1:0] req_data;
    logic          ready_req_out;
    logic [LW-1:0] level;
`ifdef REQQ_ERR_EN
    logic          err_overflow;
    logic          err_clr;
    bit            err_exp;
`endif

    logic [DW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_fail = 0;
    bit            mon_en = 1'b0;

    always #5 clk = ~clk;

    sha_req_queue #(.ADDRW(ADDRW), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .flush(flush),
        .req_valid(req_valid),
        .req_data(req_data),
        .ready_req_out(ready_req_out),
`ifdef REQQ_ERR_EN
        .err_overflow(err_overflow),
        .err_clr(err_clr),
`endif
        .level(level)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then advance the reference model across the clock edge.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r,
                                 input logic f, input logic rs);
        bit acc;
        bit ovf;
        in_valid      = v;
        in_data       = d;
        ready_req_out = r;
        flush         = f;
        rst_n         = rs;
        acc = rs && !f && v && (exp_q.size() < DEPTH);
        ovf = v && !f && (exp_q.size() == DEPTH);
        @(posedge clk);
        if (!rs || f)
            exp_q.delete();
        else if (acc)
            exp_q.push_back(d);
`ifdef REQQ_ERR_EN
        if (!rs)
            err_exp = 1'b0;
        else if (ovf)
            err_exp = 1'b1;
        else if (err_clr)
            err_exp = 1'b0;
`else
        if (ovf) begin end
`endif
        #1;
    endtask

    // Monitor: the head of the model queue must be what the DUT presents; a handshake retires it.
    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("level", 64'(level), 64'(exp_q.size()));
            checkOutput("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
            checkOutput("req_valid", 64'(req_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                checkOutput("req_data", 64'(req_data), 64'(exp_q[0]));
                if (ready_req_out && rst_n && !flush)
                    void'(exp_q.pop_front());
            end else begin
                checkOutput("req_data_idle", 64'(req_data), 64'h0);
            end
`ifdef REQQ_ERR_EN
            checkOutput("err_overflow", 64'(err_overflow), 64'(err_exp));
`endif
        end
    end

    initial begin
        logic [DW-1:0] a_word;
        bit did_rst;
        a_word = 50'h2_000100_000200;
`ifdef REQQ_ERR_EN
        err_clr = 1'b0;
        err_exp = 1'b0;
`endif
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Single descriptor held for ten cycles, then accepted.
        applyStimulus(1'b1, a_word, 1'b0, 1'b0, 1'b1);
        repeat (10) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Fill, attempt an overflow push, then drain in order.
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, DW'(i), 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, DW'(5), 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        // Pop while a push is offered at full: the push must still be dropped.
        applyStimulus(1'b1, DW'(6), 1'b1, 1'b0, 1'b1);
        repeat (4) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
`ifdef REQQ_ERR_EN
        err_clr = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        err_clr = 1'b0;
`endif
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Steady push+pop at level 2 across pointer wrap.
        applyStimulus(1'b1, DW'(11), 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, DW'(12), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, DW'(100 + i), 1'b1, 1'b0, 1'b1);
        repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Flush at level 3 with a simultaneous push.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(200 + i), 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, DW'(50'h3_BADBAD_BADBAD), 1'b0, 1'b1, 1'b1);
        repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Random traffic with one reset pulse taken at level 3.
        did_rst = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            logic          v;
            logic          r;
            logic          f;
            logic          rs;
            logic [DW-1:0] d;
            v  = ($urandom_range(0, 99) < 60);
            r  = ($urandom_range(0, 99) < 55);
            f  = ($urandom_range(0, 199) == 0);
            d  = {$urandom(), $urandom()};
            rs = 1'b1;
            if (!did_rst && i > 200 && exp_q.size() == 3) begin
                rs = 1'b0;
                did_rst = 1'b1;
            end
`ifdef REQQ_ERR_EN
            err_clr = ($urandom_range(0, 9) == 0);
`endif
            applyStimulus(v, d, r, f, rs);
        end
`ifdef REQQ_ERR_EN
        err_clr = 1'b0;
`endif
        repeat (8) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        checkOutput("drained", 64'(exp_q.size()), 64'h0);
        checkOutput("reset_pulse_taken", 64'(did_rst), 64'h1);

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
